// File: rtl/vend_pkg.sv
// vend_pkg: shared types and helpers for the multi-product vending controller.
//   - vend_state_e : controller states (IDLE, VEND, REFUND)
//   - price_of     : extracts one 4-bit slot price from the packed price vector
//   - price_ok     : elaboration-time range check of every slot price
//   - limits on product count and credit used by the parameter checks
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    REFUND = 2'd2
  } vend_state_e;

  localparam int PRICE_W          = 4;
  localparam int MAX_PRODUCTS     = 8;
  localparam int MAX_CREDIT_LIMIT = 15;
  localparam int PRICE_VEC_W      = PRICE_W * MAX_PRODUCTS;

  // Slot idx price lives at bits [4*idx+3 : 4*idx].
  function automatic logic [PRICE_W-1:0] price_of(input logic [PRICE_VEC_W-1:0] prices,
                                                  input int idx);
    price_of = prices[idx*PRICE_W +: PRICE_W];
  endfunction

  // True when every one of the first n prices lies in 1..max_credit.
  function automatic bit price_ok(input logic [PRICE_VEC_W-1:0] prices,
                                  input int n, input int max_credit);
    bit ok;
    ok = 1'b1;
    for (int j = 0; j < n; j++) begin
      if ((int'(price_of(prices, j)) < 1) || (int'(price_of(prices, j)) > max_credit)) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// vend_stock_bank: per-slot inventory counters for the vending controller.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-high reset (all slots full)
//   dec      in  NUM_PRODUCTS  one-hot decrement request (a vend from that slot)
//   restock  in  refill every slot to MAX_STOCK; wins over a same-edge decrement
//   sold_out out NUM_PRODUCTS  registered, slot j stock is zero
module vend_stock_bank #(
  parameter int NUM_PRODUCTS = 2,
  parameter int MAX_STOCK    = 15,
  localparam int STOCK_W     = $clog2(MAX_STOCK + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PRODUCTS-1:0] dec,
  input  logic                    restock,
  output logic [NUM_PRODUCTS-1:0] sold_out
);

  logic [STOCK_W-1:0]      stock_r [NUM_PRODUCTS];
  logic [STOCK_W-1:0]      stock_s [NUM_PRODUCTS];
  logic [NUM_PRODUCTS-1:0] sold_out_r;
  logic [NUM_PRODUCTS-1:0] sold_out_s;

  // Next stock per slot and the sold-out flags that follow from it.
  always_comb begin
    for (int j = 0; j < NUM_PRODUCTS; j++) begin
      stock_s[j] = stock_r[j];
      if (restock) begin
        stock_s[j] = STOCK_W'(MAX_STOCK);
      end else if (dec[j] && (stock_r[j] != {STOCK_W{1'b0}})) begin
        stock_s[j] = stock_r[j] - STOCK_W'(1'b1);
      end else begin
        stock_s[j] = stock_r[j];
      end
      sold_out_s[j] = (stock_s[j] == {STOCK_W{1'b0}});
    end
  end

  // Stock and sold-out registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_PRODUCTS; j++) begin
        stock_r[j] <= STOCK_W'(MAX_STOCK);
      end
      sold_out_r <= {NUM_PRODUCTS{1'b0}};
    end else begin
      for (int j = 0; j < NUM_PRODUCTS; j++) begin
        stock_r[j] <= stock_s[j];
      end
      sold_out_r <= sold_out_s;
    end
  end

  assign sold_out = sold_out_r;

endmodule

// File: rtl/vend_controller_multi.sv
// vend_controller_multi: N-product vending controller with bounded credit,
// per-slot inventory, coin-return sequencing and over-credit coin bounce.
// Optional feature macro: VEND_CHANGE_RETURN_EN (refund residual credit after a vend).
// Ports:
//   clk          in  system clock
//   reset        in  synchronous active-high reset
//   quarter_in   in  one quarter inserted this cycle
//   select       in  NUM_PRODUCTS  product request, lowest set index wins
//   coin_return  in  refund all credit
//   restock      in  refill every slot to MAX_STOCK
//   credit       out CREDIT_W  current credit in quarters
//   product      out NUM_PRODUCTS  one-hot one-cycle dispense pulse
//   quarter_out  out one quarter returned this cycle
//   sold_out     out NUM_PRODUCTS  slot stock is zero
//   busy         out controller not in IDLE
// All outputs are registered.
module vend_controller_multi
  import vend_pkg::*;
#(
  parameter int                        NUM_PRODUCTS = 2,
  parameter int                        MAX_CREDIT   = 3,
  parameter logic [NUM_PRODUCTS*4-1:0] PRICES       = {4'd3, 4'd2},
  parameter int                        MAX_STOCK    = 15,
  localparam int                       CREDIT_W     = $clog2(MAX_CREDIT + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    quarter_in,
  input  logic [NUM_PRODUCTS-1:0] select,
  input  logic                    coin_return,
  input  logic                    restock,
  output logic [CREDIT_W-1:0]     credit,
  output logic [NUM_PRODUCTS-1:0] product,
  output logic                    quarter_out,
  output logic [NUM_PRODUCTS-1:0] sold_out,
  output logic                    busy
);

  localparam logic [PRICE_VEC_W-1:0] PRICE_VEC = PRICE_VEC_W'(PRICES);

  if ((NUM_PRODUCTS < 1) || (NUM_PRODUCTS > MAX_PRODUCTS)) begin : g_bad_num_products
    $error("vend_controller_multi: NUM_PRODUCTS out of range 1..8");
  end
  if ((MAX_CREDIT < 1) || (MAX_CREDIT > MAX_CREDIT_LIMIT)) begin : g_bad_max_credit
    $error("vend_controller_multi: MAX_CREDIT out of range 1..15");
  end
  if (MAX_STOCK < 1) begin : g_bad_max_stock
    $error("vend_controller_multi: MAX_STOCK must be at least 1");
  end
  if (!price_ok(PRICE_VEC, NUM_PRODUCTS, MAX_CREDIT)) begin : g_bad_prices
    $error("vend_controller_multi: every price must be within 1..MAX_CREDIT");
  end

  vend_state_e             state_r, state_s;
  logic [CREDIT_W-1:0]     credit_r, credit_s, credit_q_s;
  logic [NUM_PRODUCTS-1:0] product_r, product_s, dec_s, sel_oh_s, sold_out_s;
  logic                    quarter_out_r, quarter_out_s;
  logic                    busy_r;
  // A bounced quarter that coincided with entry into REFUND is paid out as
  // part of the refund stream instead of as a separate overlapping pulse.
  logic                    owe_r, owe_s;
  logic                    at_max_s, bounce_s, bounce_out_s, sel_valid_s;
  logic [PRICE_W-1:0]      price_s, credit_ext_s;

  // Lowest-index request, its price and whether it can be honoured now.
  always_comb begin
    sel_oh_s     = select & (~select + NUM_PRODUCTS'(1'b1));
    price_s      = {PRICE_W{1'b0}};
    for (int j = 0; j < NUM_PRODUCTS; j++) begin
      price_s = price_s | (sel_oh_s[j] ? price_of(PRICE_VEC, j) : {PRICE_W{1'b0}});
    end
    credit_ext_s = PRICE_W'(credit_r);
    sel_valid_s  = (|sel_oh_s) && ((sel_oh_s & sold_out_s) == {NUM_PRODUCTS{1'b0}}) &&
                   (credit_ext_s >= price_s);
  end

  // Credit after an inserted quarter, with bounce when already full.
  always_comb begin
    at_max_s   = (credit_r == CREDIT_W'(MAX_CREDIT));
    bounce_s   = quarter_in && at_max_s;
    credit_q_s = (quarter_in && !at_max_s) ? (credit_r + CREDIT_W'(1'b1)) : credit_r;
  end

  // Next-state, credit and pulse logic.
  always_comb begin
    state_s      = state_r;
    credit_s     = credit_r;
    product_s    = {NUM_PRODUCTS{1'b0}};
    dec_s        = {NUM_PRODUCTS{1'b0}};
    owe_s        = 1'b0;
    bounce_out_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel_valid_s) begin
          state_s   = VEND;
          product_s = sel_oh_s;
          dec_s     = sel_oh_s;
          // Price never exceeds credit and credit - price < MAX_CREDIT, so the
          // same-edge quarter always fits.
          credit_s  = CREDIT_W'(credit_ext_s - price_s + {{(PRICE_W-1){1'b0}}, quarter_in});
        end else begin
          credit_s = credit_q_s;
          if (coin_return && (credit_r != {CREDIT_W{1'b0}})) begin
            state_s = REFUND;
            owe_s   = bounce_s;
          end else begin
            bounce_out_s = bounce_s;
          end
        end
      end
      VEND: begin
        credit_s = credit_q_s;
`ifdef VEND_CHANGE_RETURN_EN
        if ((credit_q_s != {CREDIT_W{1'b0}}) || bounce_s) begin
          state_s = REFUND;
          owe_s   = bounce_s;
        end else begin
          state_s      = IDLE;
          bounce_out_s = bounce_s;
        end
`else
        state_s      = IDLE;
        bounce_out_s = bounce_s;
`endif
      end
      REFUND: begin
        if (owe_r) begin
          // This cycle pays the owed quarter; a new quarter becomes the next debt.
          credit_s = credit_r;
          owe_s    = quarter_in;
        end else if (quarter_in) begin
          // Increment and decrement cancel; refund runs one cycle longer.
          credit_s = credit_r;
        end else begin
          credit_s = credit_r - CREDIT_W'(1'b1);
          if (credit_r == CREDIT_W'(1'b1)) begin
            state_s = IDLE;
          end else begin
            state_s = REFUND;
          end
        end
      end
      default: begin
        state_s  = IDLE;
        credit_s = {CREDIT_W{1'b0}};
      end
    endcase
    quarter_out_s = (state_s == REFUND) || bounce_out_s;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      credit_r      <= {CREDIT_W{1'b0}};
      product_r     <= {NUM_PRODUCTS{1'b0}};
      quarter_out_r <= 1'b0;
      busy_r        <= 1'b0;
      owe_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      credit_r      <= credit_s;
      product_r     <= product_s;
      quarter_out_r <= quarter_out_s;
      busy_r        <= (state_s != IDLE);
      owe_r         <= owe_s;
    end
  end

  vend_stock_bank #(
    .NUM_PRODUCTS (NUM_PRODUCTS),
    .MAX_STOCK    (MAX_STOCK)
  ) u_stock (
    .clk      (clk),
    .reset    (reset),
    .dec      (dec_s),
    .restock  (restock),
    .sold_out (sold_out_s)
  );

  assign credit      = credit_r;
  assign product     = product_r;
  assign quarter_out = quarter_out_r;
  assign sold_out    = sold_out_s;
  assign busy        = busy_r;

endmodule

// File: tb/tb_vend_controller_multi.sv
// Testbench for vend_controller_multi: table of {inputs, expected outputs}
// applied one row per clock to a default instance and to a MAX_STOCK=2 instance.
// Expectations for the residual-credit rows depend on VEND_CHANGE_RETURN_EN.
module tb_vend_controller_multi;

`ifdef VEND_CHANGE_RETURN_EN
  localparam int CR = 1;
`else
  localparam int CR = 0;
`endif

  typedef struct {
    logic       rst;
    logic       q;
    logic [1:0] sel;
    logic       cr;
    logic       rs;
    int         e_credit;
    int         e_prod;
    int         e_qo;
    int         e_so;
    int         e_busy;
    int         e_s0;
    int         e_s1;
  } vec_t;

  logic       clk;
  logic       rst_a, q_a, cr_a, rs_a;
  logic [1:0] sel_a;
  logic [1:0] credit_a, prod_a, so_a;
  logic       qo_a, busy_a;
  logic       rst_b, q_b, cr_b, rs_b;
  logic [1:0] sel_b;
  logic [1:0] credit_b, prod_b, so_b;
  logic       qo_b, busy_b;

  int tests;
  int fails;

  vend_controller_multi dut (
    .clk(clk), .reset(rst_a), .quarter_in(q_a), .select(sel_a), .coin_return(cr_a),
    .restock(rs_a), .credit(credit_a), .product(prod_a), .quarter_out(qo_a),
    .sold_out(so_a), .busy(busy_a)
  );

  vend_controller_multi #(.MAX_STOCK(2)) dut2 (
    .clk(clk), .reset(rst_b), .quarter_in(q_b), .select(sel_b), .coin_return(cr_b),
    .restock(rs_b), .credit(credit_b), .product(prod_b), .quarter_out(qo_b),
    .sold_out(so_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic q, input logic [1:0] sel,
                              input logic cr, input logic rs, input int c, input int p,
                              input int qo, input int so, input int b, input int s0,
                              input int s1);
    vec_t v;
    v.rst = rst; v.q = q; v.sel = sel; v.cr = cr; v.rs = rs;
    v.e_credit = c; v.e_prod = p; v.e_qo = qo; v.e_so = so; v.e_busy = b;
    v.e_s0 = s0; v.e_s1 = s1;
    return v;
  endfunction

  task automatic check(input string name, input int row, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  // Drive one row at the falling edge, let the rising edge sample it, check at the next falling edge.
  task automatic run(input vec_t v, input bit second, input int row);
    rst_a = 1'b0; q_a = 1'b0; sel_a = 2'b00; cr_a = 1'b0; rs_a = 1'b0;
    rst_b = 1'b0; q_b = 1'b0; sel_b = 2'b00; cr_b = 1'b0; rs_b = 1'b0;
    if (second) begin
      rst_b = v.rst; q_b = v.q; sel_b = v.sel; cr_b = v.cr; rs_b = v.rs;
    end else begin
      rst_a = v.rst; q_a = v.q; sel_a = v.sel; cr_a = v.cr; rs_a = v.rs;
    end
    @(posedge clk);
    @(negedge clk);
    if (second) begin
      check("b.credit", row, int'(credit_b), v.e_credit);
      check("b.product", row, int'(prod_b), v.e_prod);
      check("b.quarter_out", row, int'(qo_b), v.e_qo);
      check("b.sold_out", row, int'(so_b), v.e_so);
      check("b.busy", row, int'(busy_b), v.e_busy);
      check("b.stock0", row, int'(dut2.u_stock.stock_r[0]), v.e_s0);
      check("b.stock1", row, int'(dut2.u_stock.stock_r[1]), v.e_s1);
    end else begin
      check("a.credit", row, int'(credit_a), v.e_credit);
      check("a.product", row, int'(prod_a), v.e_prod);
      check("a.quarter_out", row, int'(qo_a), v.e_qo);
      check("a.sold_out", row, int'(so_a), v.e_so);
      check("a.busy", row, int'(busy_a), v.e_busy);
      check("a.stock0", row, int'(dut.u_stock.stock_r[0]), v.e_s0);
      check("a.stock1", row, int'(dut.u_stock.stock_r[1]), v.e_s1);
    end
  endtask

  vec_t ta[$];
  vec_t tb[$];

  initial begin
    tests = 0;
    fails = 0;
    rst_a = 1'b0; q_a = 1'b0; sel_a = 2'b00; cr_a = 1'b0; rs_a = 1'b0;
    rst_b = 1'b0; q_b = 1'b0; sel_b = 2'b00; cr_b = 1'b0; rs_b = 1'b0;

    // Default instance: prices slot0=2, slot1=3, MAX_CREDIT=3, MAX_STOCK=15.
    //             rst q  sel   cr rs  cred prod qo so busy s0 s1
    ta.push_back(mk(1, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 15, 15)); // reset state
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  1, 0, 0, 0, 0, 15, 15));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  2, 0, 0, 0, 0, 15, 15));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  3, 0, 0, 0, 0, 15, 15));
    ta.push_back(mk(0, 0, 2'd2, 0, 0,  0, 2, 0, 0, 1, 15, 14)); // vend slot1, 3->0
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 15, 14)); // pulse gone
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  1, 0, 0, 0, 0, 15, 14));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  2, 0, 0, 0, 0, 15, 14));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  3, 0, 0, 0, 0, 15, 14));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  3, 0, 1, 0, 0, 15, 14)); // bounce at full credit
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  3, 0, 0, 0, 0, 15, 14)); // bounce is one cycle
    ta.push_back(mk(0, 0, 2'd3, 0, 0,  1, 1, 0, 0, 1, 14, 14)); // both selected: slot0 wins
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  1, 0, CR, 0, CR, 14, 14)); // change refunded or kept
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  (CR != 0) ? 0 : 1, 0, 0, 0, 0, 14, 14));
    ta.push_back(mk(0, 0, 2'd0, 1, 0,  (CR != 0) ? 0 : 1, 0, (CR != 0) ? 0 : 1, 0,
                    (CR != 0) ? 0 : 1, 14, 14));                // coin_return (ignored at 0)
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 14, 14));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  1, 0, 0, 0, 0, 14, 14));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  2, 0, 0, 0, 0, 14, 14));
    ta.push_back(mk(0, 0, 2'd2, 0, 0,  2, 0, 0, 0, 0, 14, 14)); // slot1 too dear: ignored
    ta.push_back(mk(0, 0, 2'd0, 1, 0,  2, 0, 1, 0, 1, 14, 14)); // refund of 2
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  1, 0, 1, 0, 1, 14, 14));
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 14, 14));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  1, 0, 0, 0, 0, 14, 14));
    ta.push_back(mk(0, 0, 2'd0, 1, 0,  1, 0, 1, 0, 1, 14, 14)); // refund of 1
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  1, 0, 1, 0, 1, 14, 14)); // quarter extends refund
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 14, 14));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  1, 0, 0, 0, 0, 14, 14));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  2, 0, 0, 0, 0, 14, 14));
    ta.push_back(mk(0, 0, 2'd0, 1, 0,  2, 0, 1, 0, 1, 14, 14)); // refund started
    ta.push_back(mk(1, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 15, 15)); // reset mid-refund
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 15, 15));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  1, 0, 0, 0, 0, 15, 15));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  2, 0, 0, 0, 0, 15, 15));
    ta.push_back(mk(0, 0, 2'd1, 1, 0,  0, 1, 0, 0, 1, 14, 15)); // select beats coin_return
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 14, 15));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  1, 0, 0, 0, 0, 14, 15));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  2, 0, 0, 0, 0, 14, 15));
    ta.push_back(mk(0, 1, 2'd0, 0, 0,  3, 0, 0, 0, 0, 14, 15));
    ta.push_back(mk(0, 1, 2'd2, 0, 0,  1, 2, 0, 0, 1, 14, 14)); // vend + quarter: 3-3+1
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  1, 0, CR, 0, CR, 14, 14));
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  (CR != 0) ? 0 : 1, 0, 0, 0, 0, 14, 14));
    ta.push_back(mk(0, 0, 2'd0, 1, 0,  (CR != 0) ? 0 : 1, 0, (CR != 0) ? 0 : 1, 0,
                    (CR != 0) ? 0 : 1, 14, 14));
    ta.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 14, 14));

    // MAX_STOCK=2 instance: sold-out and restock behaviour on slot 0.
    tb.push_back(mk(1, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 2, 2));
    tb.push_back(mk(0, 1, 2'd0, 0, 0,  1, 0, 0, 0, 0, 2, 2));
    tb.push_back(mk(0, 1, 2'd0, 0, 0,  2, 0, 0, 0, 0, 2, 2));
    tb.push_back(mk(0, 0, 2'd1, 0, 0,  0, 1, 0, 0, 1, 1, 2));
    tb.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 1, 2));
    tb.push_back(mk(0, 1, 2'd0, 0, 0,  1, 0, 0, 0, 0, 1, 2));
    tb.push_back(mk(0, 1, 2'd0, 0, 0,  2, 0, 0, 0, 0, 1, 2));
    tb.push_back(mk(0, 0, 2'd1, 0, 0,  0, 1, 0, 1, 1, 0, 2)); // last item: sold out
    tb.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 1, 0, 0, 2));
    tb.push_back(mk(0, 1, 2'd0, 0, 0,  1, 0, 0, 1, 0, 0, 2));
    tb.push_back(mk(0, 1, 2'd0, 0, 0,  2, 0, 0, 1, 0, 0, 2));
    tb.push_back(mk(0, 0, 2'd1, 0, 0,  2, 0, 0, 1, 0, 0, 2)); // sold-out select ignored
    tb.push_back(mk(0, 0, 2'd0, 0, 1,  2, 0, 0, 0, 0, 2, 2)); // restock
    tb.push_back(mk(0, 0, 2'd1, 0, 1,  0, 1, 0, 0, 1, 2, 2)); // restock beats decrement
    tb.push_back(mk(0, 0, 2'd0, 0, 0,  0, 0, 0, 0, 0, 2, 2));

    @(negedge clk);
    for (int i = 0; i < ta.size(); i++) begin
      run(ta[i], 1'b0, i);
    end
    for (int i = 0; i < tb.size(); i++) begin
      run(tb[i], 1'b1, i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vend_controller_multi.md
# vend_controller_multi

Parametrised successor to the two-product vending controller: N products with individual prices in quarters, a bounded credit counter, per-slot inventory with sold-out flags, coin-return/refund sequencing, and over-credit coin bounce. It sits between the coin mechanism/selection buttons and the dispensing solenoids. All outputs are derived from registered state.

## Interface
- NUM_PRODUCTS, 2, number of product slots (1..8)
- MAX_CREDIT, 3, maximum credit held, in quarters (1..15)
- PRICES, {4'd3, 4'd2}, packed NUM_PRODUCTS×4 bits; slot j price at [4j+3:4j]; each must be 1..MAX_CREDIT; elaboration error otherwise
- MAX_STOCK, 15, slot capacity; stock counters are $clog2(MAX_STOCK+1) bits
- CREDIT_W (localparam), $clog2(MAX_CREDIT+1)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- quarter_in  in  1  one quarter inserted (one per cycle max)
- select  in  NUM_PRODUCTS  product request; multiple bits set → lowest index wins
- coin_return  in  1  request refund of all credit
- restock  in  1  refill every slot to MAX_STOCK
- credit  out  CREDIT_W  current credit in quarters
- product  out  NUM_PRODUCTS  one-hot, one-cycle dispense pulse
- quarter_out  out  1  one quarter returned this cycle
- sold_out  out  NUM_PRODUCTS  slot j stock is zero
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, VEND, REFUND. Reset: IDLE, credit=0, product=0, quarter_out=0, busy=0, all stock=MAX_STOCK, sold_out=0.
- IDLE, quarter_in: credit<MAX_CREDIT → credit+1; credit==MAX_CREDIT → credit unchanged, bounce flag set, quarter_out=1 next cycle.
- IDLE, select: valid iff chosen slot j not sold out and credit ≥ PRICES[j]. Valid → state VEND, product[j]=1, stock[j]−1, credit = credit − price (+1 if quarter_in same edge; never bounced). Invalid → ignored, no state change.
- Priority in IDLE: valid select > coin_return > nothing. coin_return with credit=0 ignored; otherwise → REFUND.
- VEND lasts exactly one cycle. Exit: REFUND if change return enabled (see Configuration) and credit>0, else IDLE. quarter_in during VEND adds to credit (bounced if at MAX_CREDIT); select/coin_return ignored.
- REFUND: quarter_out=1 every cycle; credit−1 each edge; exit to IDLE on the edge where credit goes 1→0. Quarters emitted = credit at entry. quarter_in during REFUND: credit unchanged that edge (inc and dec cancel), refund extends one cycle. select/coin_return ignored.
- restock accepted in any state; overrides a same-edge stock decrement (slot ends at MAX_STOCK).
- sold_out[j] = (stock[j]==0), tracks stock registers.
- reset mid-VEND/REFUND: immediate return to reset values; pending refund credit discarded.

## Timing
- Input sampled at edge k → response visible after edge k (1-cycle latency) for credit, product, quarter_out, busy.
- product pulse exactly one cycle; never two consecutive cycles.
- REFUND of c quarters: c consecutive quarter_out cycles starting cycle after entry edge; busy high throughout.
- Bounce pulse is one cycle, only from IDLE or VEND, never overlaps REFUND.

## Configuration
- VEND_CHANGE_RETURN_EN defined: residual credit after a vend is refunded automatically (VEND → REFUND).
- Not defined: residual credit retained for further purchases; refund only via coin_return.

## Structure
- Package vend_pkg: state enum (IDLE, VEND, REFUND), price-extraction function, parameter-check constants.
- Sub-module vend_stock_bank: per-slot stock counters, decrement/restock, sold_out generation.

## Test plan
- Defaults; 3 quarters then select=2'b10 → product=2'b10 one cycle, credit 3→0, stock[1]=14.
- Defaults; 3 quarters, select=2'b01: with VEND_CHANGE_RETURN_EN → credit 1, one quarter_out, IDLE, credit 0; without → credit stays 1.
- Credit 3, quarter_in → credit stays 3, quarter_out=1 one cycle; credit 2, coin_return → two quarter_out cycles, busy high 2 cycles.
- Select slot 1 with credit 2 → ignored; select=2'b11 with credit 3 → slot 0 vends.
- MAX_STOCK=2; vend slot 0 twice → sold_out[0]=1, third select ignored; restock → sold_out[0]=0, stock 2.
- Reset asserted during REFUND with credit 2 → next cycle credit 0, quarter_out 0, busy 0.
